ps2_scan_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_scan_decoder_if.sv | 22 ++
 rtl/ps2_timer.sv | 28 ++
 rtl/ps2_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 scan-code set 2 decoder: FSM states, prefix and
// control-reply byte values, and Pause sequence length.
package ps2_pkg;

   localparam logic [2:0] ST_IDLE_C    = 3'd0;
   localparam logic [2:0] ST_EXT_C     = 3'd1;
   localparam logic [2:0] ST_BRK_C     = 3'd2;
   localparam logic [2:0] ST_EXT_BRK_C = 3'd3;
   localparam logic [2:0] ST_PAUSE_C   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE_C,
      S_EXT     = ST_EXT_C,
      S_BRK     = ST_BRK_C,
      S_EXT_BRK = ST_EXT_BRK_C,
      S_PAUSE   = ST_PAUSE_C
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   localparam logic [2:0] PAUSE_TAIL = 3'd7;

   function automatic logic is_ctrl_reply(input logic [7:0] b);
      return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ECHO);
   endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Byte-in / key-event-out bundle of the scan decoder; slave is the decoder side,
// master is the receiver/consumer side.
interface ps2_scan_decoder_if;
   logic       i_byte_en;
   logic [7:0] i_byte;
   logic       o_key_en;
   logic [7:0] o_key_code;
   logic       o_key_ext;
   logic       o_key_break;
   logic       o_pause;
   logic       o_err;

   modport master (
      output i_byte_en, i_byte,
      input  o_key_en, o_key_code, o_key_ext, o_key_break, o_pause, o_err
   );

   modport slave (
      input  i_byte_en, i_byte,
      output o_key_en, o_key_code, o_key_ext, o_key_break, o_pause, o_err
   );
endinterface

// File: rtl/ps2_timer.sv
// Saturating inter-byte timeout counter; o_expire is high in the cycle the count
// sits at TIMEOUT_CYCLES-1 while enabled and not being cleared.
module ps2_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic i_sclr_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!i_sclr_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en && (r_cnt != CNT_MAX))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_expire = i_en && !i_clr && (r_cnt == CNT_LAST);
endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 byte stream to key events (E0/F0/E1 prefixes, error and timeout flags).
// Optional typematic repeat suppression: define PS2_REPEAT_FILTER_EN.
module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic               clk,
   input  logic               i_sclr_n,
   ps2_scan_decoder_if.slave  bus
);
   ps2_state_t r_state, w_state_nxt;
   logic [2:0] r_pcnt, w_pcnt_nxt;
   logic       w_ev, w_ev_ext, w_ev_brk, w_err, w_pause, w_emit, w_expire;
   logic       r_key_en, r_key_ext, r_key_break, r_pause, r_err;
   logic [7:0] r_key_code;

   ps2_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk      (clk),
      .i_sclr_n (i_sclr_n),
      .i_clr    (bus.i_byte_en || (r_state == S_IDLE)),
      .i_en     (r_state != S_IDLE),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (!i_sclr_n) begin
         r_state <= S_IDLE;
         r_pcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pcnt  <= w_pcnt_nxt;
      end
   end

   // A byte always wins over a coinciding timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_pcnt_nxt  = r_pcnt;
      w_ev        = 1'b0;
      w_ev_ext    = 1'b0;
      w_ev_brk    = 1'b0;
      w_err       = 1'b0;
      w_pause     = 1'b0;
      if (bus.i_byte_en) begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_byte == PS2_EXT)
                  w_state_nxt = S_EXT;
               else if (bus.i_byte == PS2_BRK)
                  w_state_nxt = S_BRK;
               else if (bus.i_byte == PS2_PAUSE) begin
                  w_state_nxt = S_PAUSE;
                  w_pcnt_nxt  = PAUSE_TAIL;
               end else if (bus.i_byte inside {PS2_ERR0, PS2_ERR1})
                  w_err = 1'b1;
               else if (!is_ctrl_reply(bus.i_byte))
                  w_ev = 1'b1;
            end
            S_EXT: begin
               w_state_nxt = S_IDLE;
               if (bus.i_byte == PS2_BRK)
                  w_state_nxt = S_EXT_BRK;
               else if (bus.i_byte inside {PS2_ERR0, PS2_ERR1, PS2_EXT, PS2_PAUSE})
                  w_err = 1'b1;
               else begin
                  w_ev     = 1'b1;
                  w_ev_ext = 1'b1;
               end
            end
            S_BRK, S_EXT_BRK: begin
               w_state_nxt = S_IDLE;
               if (bus.i_byte inside {PS2_ERR0, PS2_ERR1, PS2_EXT, PS2_PAUSE, PS2_BRK})
                  w_err = 1'b1;
               else begin
                  w_ev     = 1'b1;
                  w_ev_brk = 1'b1;
                  w_ev_ext = (r_state == S_EXT_BRK);
               end
            end
            S_PAUSE: begin
               if (r_pcnt <= 3'd1) begin
                  w_pause     = 1'b1;
                  w_state_nxt = S_IDLE;
                  w_pcnt_nxt  = '0;
               end else
                  w_pcnt_nxt = r_pcnt - 3'd1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (w_expire) begin
         w_err       = 1'b1;
         w_state_nxt = S_IDLE;
         w_pcnt_nxt  = '0;
      end
   end

`ifdef PS2_REPEAT_FILTER_EN
   logic [7:0] r_last_code;
   logic       r_last_ext, r_last_vld, w_same;

   assign w_same = ({r_last_ext, r_last_code} == {w_ev_ext, bus.i_byte});
   assign w_emit = w_ev && !(!w_ev_brk && r_last_vld && w_same);

   always_ff @(posedge clk) begin
      if (!i_sclr_n) begin
         r_last_code <= '0;
         r_last_ext  <= 1'b0;
         r_last_vld  <= 1'b0;
      end else if (w_ev && w_ev_brk) begin
         if (w_same)
            r_last_vld <= 1'b0;
      end else if (w_ev && !(r_last_vld && w_same)) begin
         r_last_code <= bus.i_byte;
         r_last_ext  <= w_ev_ext;
         r_last_vld  <= 1'b1;
      end
   end
`else
   assign w_emit = w_ev;
`endif

   always_ff @(posedge clk) begin
      if (!i_sclr_n) begin
         r_key_en    <= 1'b0;
         r_key_code  <= '0;
         r_key_ext   <= 1'b0;
         r_key_break <= 1'b0;
         r_pause     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_key_en <= w_emit;
         r_pause  <= w_pause;
         r_err    <= w_err;
         if (w_emit) begin
            r_key_code  <= bus.i_byte;
            r_key_ext   <= w_ev_ext;
            r_key_break <= w_ev_brk;
         end
      end
   end

   assign bus.o_key_en    = r_key_en;
   assign bus.o_key_code  = r_key_code;
   assign bus.o_key_ext   = r_key_ext;
   assign bus.o_key_break = r_key_break;
   assign bus.o_pause     = r_pause;
   assign bus.o_err       = r_err;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: grammar-level reference model checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_ps2_scan_decoder;
   localparam int T = 16;

   logic clk = 1'b0;
   logic sclr_n = 1'b0;
   always #5 clk = ~clk;

   ps2_scan_decoder_if bus();

   ps2_scan_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk      (clk),
      .i_sclr_n (sclr_n),
      .bus      (bus)
   );

   int n_chk = 0, n_pass = 0;
   int n_key = 0, n_pause = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Inputs as seen by the DUT at the last rising edge.
   logic       s_rst, s_en;
   logic [7:0] s_b;
   always @(posedge clk) begin
      s_rst <= sclr_n;
      s_en  <= bus.i_byte_en;
      s_b   <= bus.i_byte;
   end

   // Reference model: pending prefix bytes plus idle-cycle count since the last byte.
   logic [7:0] seq[$];
   int         since = 0;
   logic       e_key = 0, e_ext = 0, e_brk = 0, e_pause = 0, e_err = 0;
   logic [7:0] e_code = 0;
`ifdef PS2_REPEAT_FILTER_EN
   logic       f_vld = 0, f_ext = 0;
   logic [7:0] f_code = 0;
`endif

   task automatic emit(input logic x, input logic k, input logic [7:0] c);
`ifdef PS2_REPEAT_FILTER_EN
      if (!k) begin
         if (f_vld && f_ext == x && f_code == c) return;
         f_vld = 1; f_ext = x; f_code = c;
      end else if (f_ext == x && f_code == c) f_vld = 0;
`endif
      e_key = 1; e_code = c; e_ext = x; e_brk = k;
   endtask

   task automatic feed(input logic [7:0] b);
      int pid;
      if (seq.size() != 0 && seq[0] == 8'hE1) begin
         seq.push_back(b);
         if (seq.size() == 8) begin e_pause = 1; seq.delete(); end
         return;
      end
      // pid: 0 none, 1 {E0}, 2 {F0}, 3 {E0,F0}, -1 not a legal prefix
      pid = -1;
      if (seq.size() == 0) pid = 0;
      else if (seq.size() == 1) pid = (seq[0] == 8'hE0) ? 1 : (seq[0] == 8'hF0) ? 2 : -1;
      else if (seq.size() == 2) pid = (seq[0] == 8'hE0 && seq[1] == 8'hF0) ? 3 : -1;
      if ((pid == 0 && (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)) || (pid == 1 && b == 8'hF0)) begin
         seq.push_back(b);
         return;
      end
      seq.delete();
      if (pid >= 0 && !(b inside {8'h00, 8'hFF, 8'hE0, 8'hE1, 8'hF0})) begin
         if (!(pid == 0 && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE})))
            emit(pid == 1 || pid == 3, pid == 2 || pid == 3, b);
      end else
         e_err = 1;
   endtask

   task automatic model_step(input logic rst, input logic en, input logic [7:0] b);
      e_key = 0; e_pause = 0; e_err = 0;
      if (!rst) begin
         seq.delete(); since = 0;
         e_code = 0; e_ext = 0; e_brk = 0;
`ifdef PS2_REPEAT_FILTER_EN
         f_vld = 0; f_ext = 0; f_code = 0;
`endif
         return;
      end
      if (en) begin
         since = 0;
         feed(b);
      end else if (seq.size() != 0) begin
         since++;
         if (since == T) begin e_err = 1; seq.delete(); end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_step(s_rst, s_en, s_b);
         chk("cycle", 32'({bus.o_key_en, bus.o_key_code, bus.o_key_ext, bus.o_key_break, bus.o_pause, bus.o_err}),
             32'({e_key, e_code, e_ext, e_brk, e_pause, e_err}));
         if (bus.o_key_en === 1'b1) n_key++;
         if (bus.o_pause === 1'b1) n_pause++;
         if (bus.o_err === 1'b1) n_err++;
      end
   end

   task automatic send(input logic [7:0] b);
      bus.i_byte_en = 1'b1;
      bus.i_byte    = b;
      @(negedge clk);
      bus.i_byte_en = 1'b0;
      bus.i_byte    = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      sclr_n = 1'b0;
      @(negedge clk);
      sclr_n = 1'b1;
   endtask

   function automatic logic [31:0] key_vec();
      return 32'({bus.o_key_en, bus.o_key_code, bus.o_key_ext, bus.o_key_break});
   endfunction

   int k0, p0, r0;
   logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
   logic [7:0] junk_seq  [5] = '{8'hFA, 8'hAA, 8'h00, 8'hF0, 8'hE0};
   logic [7:0] rep_seq   [7] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'h1C};

   initial begin
      bus.i_byte_en = 1'b0;
      bus.i_byte    = 8'h00;
      idle(3);
      sclr_n = 1'b1;
      chk("reset_outs", 32'({bus.o_key_en, bus.o_key_code, bus.o_key_ext, bus.o_key_break, bus.o_pause, bus.o_err}), 32'h0);
      idle(2);

      // plain make, then hold
      send(8'h1C);
      chk("make_1c", key_vec(), 32'({1'b1, 8'h1C, 1'b0, 1'b0}));
      idle(3);
      chk("make_hold", key_vec(), 32'({1'b0, 8'h1C, 1'b0, 1'b0}));

      // break and extended break, second one back-to-back
      #1; k0 = n_key; r0 = n_err; p0 = n_pause;
      send(8'hF0); idle(2); send(8'h1C);
      chk("brk_1c", key_vec(), 32'({1'b1, 8'h1C, 1'b0, 1'b1}));
      idle(20);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext_brk_75", key_vec(), 32'({1'b1, 8'h75, 1'b1, 1'b1}));
      idle(20); #1;
      chk("brk_keys", n_key - k0, 2);
      chk("brk_noerr", (n_err - r0) + (n_pause - p0), 0);

      // Pause sequence
      k0 = n_key; p0 = n_pause;
      for (int i = 0; i < 8; i++) begin send(pause_seq[i]); idle(i % 2); end
      idle(3); #1;
      chk("pause_cnt", n_pause - p0, 1);
      chk("pause_nokey", n_key - k0, 0);

      // timeout after E0, then a fresh make
      r0 = n_err;
      send(8'hE0); idle(15); #1;
      chk("to_early", n_err - r0, 0);
      idle(1); #1;
      chk("to_fire", n_err - r0, 1);
      idle(2);
      send(8'h1C);
      chk("to_after", key_vec(), 32'({1'b1, 8'h1C, 1'b0, 1'b0}));
      idle(2);

      // byte landing on the expiry cycle wins
      r0 = n_err;
      send(8'hE0); idle(15); send(8'h74);
      chk("to_coincide", key_vec(), 32'({1'b1, 8'h74, 1'b1, 1'b0}));
      idle(20); #1;
      chk("to_coincide_noerr", n_err - r0, 0);

      // reset mid-sequence drops the E0
      send(8'hE0); pulse_reset();
      chk("rst_mid", 32'({bus.o_key_en, bus.o_key_code, bus.o_key_ext, bus.o_key_break, bus.o_pause, bus.o_err}), 32'h0);
      send(8'h75);
      chk("rst_75", key_vec(), 32'({1'b1, 8'h75, 1'b0, 1'b0}));
      idle(2);

      // control replies, error byte, illegal prefix order
      #1; k0 = n_key; r0 = n_err;
      for (int i = 0; i < 5; i++) send(junk_seq[i]);
      idle(3); #1;
      chk("junk_nokey", n_key - k0, 0);
      chk("junk_err", n_err - r0, 2);
      send(8'h1C);
      chk("junk_recover", key_vec(), 32'({1'b1, 8'h1C, 1'b0, 1'b0}));
      idle(2);

      // typematic repeats
      pulse_reset(); idle(1);
      #1; k0 = n_key;
      for (int i = 0; i < 6; i++) send(rep_seq[i]);
      idle(3); #1;
`ifdef PS2_REPEAT_FILTER_EN
      chk("repeat_keys", n_key - k0, 3);
`else
      chk("repeat_keys", n_key - k0, 5);
`endif
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
